// File: rtl/eth_tx_stream_arbiter.sv
// eth_tx_stream_arbiter
//   Frame-granular round-robin arbiter that shares one AXI-Stream TX port
//   among NUM_REQ requesters. The grant is held from the first beat to tlast,
//   so frames never interleave. Arbitration costs one idle cycle per frame.
//   Optional feature: define ETH_TX_ARB_TIMEOUT_EN to abort a frame whose
//   source stalls for TIMEOUT cycles. The abort emits a synthetic errored
//   tlast beat, pulses abort_o and then flushes the rest of the source frame.
module eth_tx_stream_arbiter #(
  parameter int NUM_REQ    = 2,
  parameter int DW         = 64,
  parameter int USER_WIDTH = 1,
  parameter int TIMEOUT    = 256
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic [NUM_REQ*DW-1:0]         s_tdata_i,
  input  logic [NUM_REQ*(DW/8)-1:0]     s_tkeep_i,
  input  logic [NUM_REQ*USER_WIDTH-1:0] s_tuser_i,
  input  logic [NUM_REQ-1:0]            s_tlast_i,
  input  logic [NUM_REQ-1:0]            s_tvalid_i,
  output logic [NUM_REQ-1:0]            s_tready_o,
  output logic [DW-1:0]                 m_tdata_o,
  output logic [DW/8-1:0]               m_tkeep_o,
  output logic [USER_WIDTH-1:0]         m_tuser_o,
  output logic                          m_tlast_o,
  output logic                          m_tvalid_o,
  input  logic                          m_tready_i,
  output logic [NUM_REQ-1:0]            grant_o,
  output logic                          busy_o,
  output logic                          abort_o
);

  localparam int KW = DW / 8;
  localparam int IW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_param
    $error("eth_tx_stream_arbiter: unsupported parameterisation");
  end

`ifdef ETH_TX_ARB_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, BUSY, FLUSH} state_t;
`else
  typedef enum logic [0:0] {IDLE, BUSY} state_t;
`endif

  state_t               state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [IW-1:0]        gidx_q, gidx_d;
  logic [IW-1:0]        last_q, last_d;

  logic                 pick_found;
  logic [IW-1:0]        pick_idx;

  logic [DW-1:0]         sel_data;
  logic [KW-1:0]         sel_keep;
  logic [USER_WIDTH-1:0] sel_user;
  logic                  sel_last;
  logic                  sel_valid;
  logic                  synth;

`ifdef ETH_TX_ARB_TIMEOUT_EN
  localparam int CW_RAW = $clog2(TIMEOUT + 1);
  localparam int CW     = (CW_RAW < 9) ? 9 : ((CW_RAW > 16) ? 16 : CW_RAW);
  logic [CW-1:0] stall_q, stall_d;
  logic          abort_q, abort_d;

  assign synth   = (state_q == BUSY) && (stall_q == CW'(TIMEOUT));
  assign abort_o = abort_q;
`else
  assign synth   = 1'b0;
  assign abort_o = 1'b0;
`endif

  // Current owner's stream, selected by the registered grant index.
  assign sel_data  = s_tdata_i[int'(gidx_q)*DW +: DW];
  assign sel_keep  = s_tkeep_i[int'(gidx_q)*KW +: KW];
  assign sel_user  = s_tuser_i[int'(gidx_q)*USER_WIDTH +: USER_WIDTH];
  assign sel_last  = s_tlast_i[gidx_q];
  assign sel_valid = s_tvalid_i[gidx_q];

  assign grant_o = grant_q;
  assign busy_o  = (state_q != IDLE);

  // Round-robin search: first valid requester after the last owner, with wrap.
  always_comb begin
    int unsigned cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int unsigned off = 1; off <= NUM_REQ; off++) begin
      cand = (32'(last_q) + off) % NUM_REQ;
      if (!pick_found && s_tvalid_i[cand]) begin
        pick_found = 1'b1;
        pick_idx   = IW'(cand);
      end
    end
  end

  // Next-state and output decode; outputs are forced quiet while reset is low.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    gidx_d     = gidx_q;
    last_d     = last_q;
    m_tdata_o  = '0;
    m_tkeep_o  = '0;
    m_tuser_o  = '0;
    m_tlast_o  = 1'b0;
    m_tvalid_o = 1'b0;
    s_tready_o = '0;
`ifdef ETH_TX_ARB_TIMEOUT_EN
    stall_d    = stall_q;
    abort_d    = 1'b0;
`endif
    if (rst_ni) begin
      case (state_q)
        IDLE: begin
          if (pick_found) begin
            gidx_d           = pick_idx;
            grant_d          = '0;
            grant_d[pick_idx] = 1'b1;
            state_d          = BUSY;
`ifdef ETH_TX_ARB_TIMEOUT_EN
            stall_d          = '0;
`endif
          end
        end
        BUSY: begin
          if (synth) begin
            // Synthetic errored tlast beat; the source sees no ready.
            m_tvalid_o   = 1'b1;
            m_tlast_o    = 1'b1;
            m_tuser_o[0] = 1'b1;
`ifdef ETH_TX_ARB_TIMEOUT_EN
            if (m_tready_i) begin
              abort_d = 1'b1;
              state_d = FLUSH;
            end
`endif
          end else begin
            m_tdata_o          = sel_data;
            m_tkeep_o          = sel_keep;
            m_tuser_o          = sel_user;
            m_tlast_o          = sel_last;
            m_tvalid_o         = sel_valid;
            s_tready_o[gidx_q] = m_tready_i;
            if (sel_valid && m_tready_i) begin
`ifdef ETH_TX_ARB_TIMEOUT_EN
              stall_d = '0;
`endif
              if (sel_last) begin
                last_d  = gidx_q;
                grant_d = '0;
                state_d = IDLE;
              end
            end
`ifdef ETH_TX_ARB_TIMEOUT_EN
            else if (!sel_valid) begin
              stall_d = stall_q + 1'b1;
            end
`endif
          end
        end
`ifdef ETH_TX_ARB_TIMEOUT_EN
        FLUSH: begin
          s_tready_o[gidx_q] = 1'b1;
          if (sel_valid && sel_last) begin
            last_d  = gidx_q;
            grant_d = '0;
            state_d = IDLE;
          end
        end
`endif
        default: state_d = IDLE;
      endcase
    end
  end

  // State, grant and round-robin pointer registers.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      last_q  <= IW'(NUM_REQ - 1);
`ifdef ETH_TX_ARB_TIMEOUT_EN
      stall_q <= '0;
      abort_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      gidx_q  <= gidx_d;
      last_q  <= last_d;
`ifdef ETH_TX_ARB_TIMEOUT_EN
      stall_q <= stall_d;
      abort_q <= abort_d;
`endif
    end
  end

endmodule

// File: tb/tb_eth_tx_stream_arbiter.sv
// Self-checking bench for eth_tx_stream_arbiter (NUM_REQ=3, DW=64).
`timescale 1ns/1ps
module tb_eth_tx_stream_arbiter;
  localparam int N = 3;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  logic [N*64-1:0]   s_tdata_i;
  logic [N*8-1:0]    s_tkeep_i;
  logic [N-1:0]      s_tuser_i;
  logic [N-1:0]      s_tlast_i;
  logic [N-1:0]      s_tvalid_i;
  logic [N-1:0]      s_tready_o;
  logic [63:0]       m_tdata_o;
  logic [7:0]        m_tkeep_o;
  logic [0:0]        m_tuser_o;
  logic              m_tlast_o;
  logic              m_tvalid_o;
  logic              m_tready_i;
  logic [N-1:0]      grant_o;
  logic              busy_o;
  logic              abort_o;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] v, l;
    logic         r;
    logic         ev;
    logic [N-1:0] etr, eg;
    logic         eb, el;
  } vec_t;

  typedef struct {
    logic [63:0] d;
    logic [7:0]  k;
    logic        u;
    logic        l;
  } beat_t;

  beat_t srcq[N][$];
  int    gseq[$];

  always #4 clk_i = ~clk_i;

  eth_tx_stream_arbiter #(
    .NUM_REQ(N), .DW(64), .USER_WIDTH(1), .TIMEOUT(16)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .s_tdata_i(s_tdata_i), .s_tkeep_i(s_tkeep_i), .s_tuser_i(s_tuser_i),
    .s_tlast_i(s_tlast_i), .s_tvalid_i(s_tvalid_i), .s_tready_o(s_tready_o),
    .m_tdata_o(m_tdata_o), .m_tkeep_o(m_tkeep_o), .m_tuser_o(m_tuser_o),
    .m_tlast_o(m_tlast_o), .m_tvalid_o(m_tvalid_o), .m_tready_i(m_tready_i),
    .grant_o(grant_o), .busy_o(busy_o), .abort_o(abort_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Round-robin rule: first requesting index after the previous owner, wrapping.
  function automatic int rr_pick(input logic [N-1:0] req, input int after);
    for (int k = 1; k <= N; k++)
      if (req[(after + k) % N]) return (after + k) % N;
    return -1;
  endfunction

  function automatic logic [63:0] t2_beat(input int k);
    logic [63:0] r;
    for (int j = 0; j < 8; j++) r[8*j +: 8] = 8'(8*k + 40 + j);
    return r;
  endfunction

  // Holds reset for a number of cycles; leaves the bench at a negedge, reset released.
  task automatic do_reset(input bit with_valid, input int cycles);
    rst_ni     = 1'b0;
    s_tvalid_i = with_valid ? '1 : '0;
    s_tlast_i  = '0;
    m_tready_i = 1'b1;
    repeat (cycles) begin
      @(negedge clk_i);
      if (with_valid) begin
        check("rst_mvalid", 64'(m_tvalid_o), 64'd0);
        check("rst_tready", 64'(s_tready_o), 64'd0);
        check("rst_grant",  64'(grant_o),    64'd0);
        check("rst_busy",   64'(busy_o),     64'd0);
      end
    end
    @(negedge clk_i);
    rst_ni     = 1'b1;
    s_tvalid_i = '0;
  endtask

  // Random traffic against a frame-level scoreboard and round-robin model.
  task automatic run_random(input int nfr, input int flen, input bit allv, input bit allr, input int budget);
    int owner, lastp, stall, cyc, pending, len;
    logic [N-1:0] vld, expg;
    beat_t b;
    owner = -1; lastp = N - 1; stall = 0; cyc = 0; vld = '0;
    gseq.delete();
    for (int i = 0; i < N; i++) begin
      srcq[i].delete();
      for (int f = 0; f < nfr; f++) begin
        len = (flen > 0) ? flen : int'($urandom_range(1, 6));
        for (int j = 0; j < len; j++) begin
          b.d = {$urandom, $urandom};
          b.k = 8'($urandom);
          b.u = 1'($urandom);
          b.l = (j == len - 1);
          srcq[i].push_back(b);
        end
      end
    end
    forever begin
      pending = 0;
      for (int i = 0; i < N; i++) pending += srcq[i].size();
      if ((pending == 0 && owner < 0) || cyc >= budget) break;
      for (int i = 0; i < N; i++) begin
        if (!vld[i] && srcq[i].size() != 0 && (allv || $urandom_range(0, 2) == 0)) vld[i] = 1'b1;
        if (srcq[i].size() != 0) begin
          s_tdata_i[i*64 +: 64] = srcq[i][0].d;
          s_tkeep_i[i*8 +: 8]   = srcq[i][0].k;
          s_tuser_i[i]          = srcq[i][0].u;
          s_tlast_i[i]          = srcq[i][0].l;
        end else begin
          s_tdata_i[i*64 +: 64] = '0;
          s_tkeep_i[i*8 +: 8]   = '0;
          s_tuser_i[i]          = 1'b0;
          s_tlast_i[i]          = 1'b0;
        end
      end
      s_tvalid_i = vld;
      if (allr) m_tready_i = 1'b1;
      else if (stall > 0) begin
        m_tready_i = 1'b0;
        stall--;
      end else begin
        m_tready_i = 1'b1;
        if ($urandom_range(0, 5) == 0) stall = int'($urandom_range(0, 50));
      end
      #1;
      expg = '0;
      if (owner >= 0) expg[owner] = 1'b1;
      check("rnd_grant",  64'(grant_o),    64'(expg));
      check("rnd_busy",   64'(busy_o),     64'(owner >= 0));
      check("rnd_tready", 64'(s_tready_o), 64'(m_tready_i ? expg : '0));
      check("rnd_mvalid", 64'(m_tvalid_o), 64'((owner >= 0) ? vld[owner] : 1'b0));
      if (owner >= 0 && vld[owner] && m_tready_i) begin
        b = srcq[owner].pop_front();
        check("rnd_data", m_tdata_o, b.d);
        check("rnd_ctl", 64'({m_tlast_o, m_tuser_o, m_tkeep_o}), 64'({b.l, b.u, b.k}));
        vld[owner] = 1'b0;
        if (b.l) begin
          lastp = owner;
          owner = -1;
        end
      end else if (owner < 0 && vld != '0) begin
        owner = rr_pick(vld, lastp);
        gseq.push_back(owner);
      end
      cyc++;
      @(negedge clk_i);
    end
    check("rnd_within_budget", 64'(cyc < budget), 64'd1);
    s_tvalid_i = '0;
    m_tready_i = 1'b1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[16];
    logic [63:0] td[N];
    logic [7:0]  tk[N];
    logic [N-1:0] tu;
    logic [63:0] d;
    int          o, n;

    s_tdata_i = '0; s_tkeep_i = '0; s_tuser_i = '0; s_tlast_i = '0;
    s_tvalid_i = '0; m_tready_i = 1'b1; rst_ni = 1'b0;

    // T1: reset with all sources valid.
    do_reset(1'b1, 10);

    // Table: arbitration, late arrival, single-beat frames, source gaps.
    td[0] = 64'hAAAA_0000_0000_00A0; td[1] = 64'hBBBB_1111_0000_00B1; td[2] = 64'hCCCC_2222_0000_00C2;
    tk[0] = 8'hFF; tk[1] = 8'hF0; tk[2] = 8'h0F;
    tu    = 3'b101;
    for (int i = 0; i < N; i++) begin
      s_tdata_i[i*64 +: 64] = td[i];
      s_tkeep_i[i*8 +: 8]   = tk[i];
    end
    s_tuser_i = tu;
    //           valid   last    rdy mv  tready  grant   busy mlast
    tbl[0]  = '{3'b001, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0};
    tbl[1]  = '{3'b001, 3'b000, 1, 1, 3'b001, 3'b001, 1, 0};
    tbl[2]  = '{3'b011, 3'b001, 0, 1, 3'b000, 3'b001, 1, 1};
    tbl[3]  = '{3'b011, 3'b001, 1, 1, 3'b001, 3'b001, 1, 1};
    tbl[4]  = '{3'b011, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0};
    tbl[5]  = '{3'b011, 3'b011, 1, 1, 3'b010, 3'b010, 1, 1};
    tbl[6]  = '{3'b111, 3'b111, 1, 0, 3'b000, 3'b000, 0, 0};
    tbl[7]  = '{3'b111, 3'b111, 1, 1, 3'b100, 3'b100, 1, 1};
    tbl[8]  = '{3'b111, 3'b111, 1, 0, 3'b000, 3'b000, 0, 0};
    tbl[9]  = '{3'b110, 3'b111, 1, 0, 3'b001, 3'b001, 1, 1};
    tbl[10] = '{3'b111, 3'b111, 1, 1, 3'b001, 3'b001, 1, 1};
    tbl[11] = '{3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0};
    tbl[12] = '{3'b010, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0};
    tbl[13] = '{3'b010, 3'b000, 1, 1, 3'b010, 3'b010, 1, 0};
    tbl[14] = '{3'b010, 3'b010, 1, 1, 3'b010, 3'b010, 1, 1};
    tbl[15] = '{3'b000, 3'b000, 1, 0, 3'b000, 3'b000, 0, 0};
    for (int i = 0; i < 16; i++) begin
      s_tvalid_i = tbl[i].v;
      s_tlast_i  = tbl[i].l;
      m_tready_i = tbl[i].r;
      #1;
      check($sformatf("tbl%0d_mvalid", i), 64'(m_tvalid_o), 64'(tbl[i].ev));
      check($sformatf("tbl%0d_tready", i), 64'(s_tready_o), 64'(tbl[i].etr));
      check($sformatf("tbl%0d_grant", i),  64'(grant_o),    64'(tbl[i].eg));
      check($sformatf("tbl%0d_busy", i),   64'(busy_o),     64'(tbl[i].eb));
      if (tbl[i].eg != '0) begin
        o = 0;
        for (int k = 0; k < N; k++) if (tbl[i].eg[k]) o = k;
        check($sformatf("tbl%0d_data", i), m_tdata_o, td[o]);
        check($sformatf("tbl%0d_ctl", i), 64'({m_tlast_o, m_tuser_o, m_tkeep_o}),
              64'({tbl[i].el, tu[o], tk[o]}));
      end
      @(negedge clk_i);
    end

    // T2: single requester, 8-beat frame, bit-exact, one bubble.
    do_reset(1'b0, 2);
    s_tkeep_i = '1; s_tuser_i = '0; m_tready_i = 1'b1;
    s_tvalid_i = 3'b001; s_tlast_i = '0; s_tdata_i[63:0] = t2_beat(0);
    #1;
    check("t2_bubble_mvalid", 64'(m_tvalid_o), 64'd0);
    check("t2_bubble_grant",  64'(grant_o),    64'd0);
    @(negedge clk_i);
    for (int k = 0; k < 8; k++) begin
      d = t2_beat(k);
      s_tdata_i[63:0] = d;
      s_tlast_i[0]    = (k == 7);
      #1;
      check("t2_mvalid", 64'(m_tvalid_o), 64'd1);
      check("t2_data",   m_tdata_o, d);
      check("t2_grant",  64'(grant_o), 64'd1);
      check("t2_busy",   64'(busy_o),  64'd1);
      check("t2_last",   64'(m_tlast_o), 64'(k == 7));
      if (k == 7) check("t2_final_data", m_tdata_o, 64'h6766656463626160);
      @(negedge clk_i);
    end
    s_tvalid_i = '0; s_tlast_i = '0;
    #1;
    check("t2_busy_after", 64'(busy_o),  64'd0);
    check("t2_grant_after", 64'(grant_o), 64'd0);
    @(negedge clk_i);

    // T3: full contention, 4-beat frames, expected grant order 0,1,2,0,1,2.
    do_reset(1'b0, 2);
    run_random(2, 4, 1'b1, 1'b1, 400);
    check("t3_grant_count", 64'(gseq.size()), 64'd6);
    for (int k = 0; k < gseq.size(); k++) check("t3_order", 64'(gseq[k]), 64'(k % N));

    // T4: random backpressure and source gaps.
    do_reset(1'b0, 2);
    run_random(4, 0, 1'b0, 1'b0, 20000);

`ifdef ETH_TX_ARB_TIMEOUT_EN
    // T6: req0 stalls mid-frame; timeout abort, flush, then req1 served.
    do_reset(1'b0, 2);
    s_tkeep_i = '1; s_tuser_i = '0; m_tready_i = 1'b1;
    s_tdata_i[127:64] = 64'h1111_2222_3333_4444;
    s_tlast_i = 3'b010; s_tvalid_i = 3'b011; s_tdata_i[63:0] = 64'h100;
    #1;
    check("t6_bubble", 64'(m_tvalid_o), 64'd0);
    @(negedge clk_i);
    for (int k = 0; k < 3; k++) begin
      s_tdata_i[63:0] = 64'h100 + 64'(k);
      #1;
      check("t6_beat_valid", 64'(m_tvalid_o), 64'd1);
      check("t6_beat_data",  m_tdata_o, 64'h100 + 64'(k));
      check("t6_beat_grant", 64'(grant_o), 64'd1);
      @(negedge clk_i);
    end
    s_tvalid_i[0] = 1'b0;
    n = 0;
    forever begin
      #1;
      if (m_tvalid_o || n >= 40) break;
      n++;
      @(negedge clk_i);
    end
    check("t6_stall_cycles", 64'(n), 64'd16);
    check("t6_synth_ctl", 64'({m_tvalid_o, m_tlast_o, m_tuser_o, m_tkeep_o}), 64'({1'b1, 1'b1, 1'b1, 8'h00}));
    check("t6_synth_data", m_tdata_o, 64'd0);
    check("t6_synth_tready", 64'(s_tready_o), 64'd0);
    @(negedge clk_i);
    #1;
    check("t6_abort_pulse", 64'(abort_o), 64'd1);
    check("t6_flush_mvalid", 64'(m_tvalid_o), 64'd0);
    check("t6_flush_tready", 64'(s_tready_o), 64'd1);
    check("t6_flush_busy", 64'(busy_o), 64'd1);
    @(negedge clk_i);
    for (int k = 3; k < 6; k++) begin
      s_tvalid_i[0] = 1'b1;
      s_tlast_i[0]  = (k == 5);
      s_tdata_i[63:0] = 64'h100 + 64'(k);
      #1;
      check("t6_sink_mvalid", 64'(m_tvalid_o), 64'd0);
      check("t6_sink_tready", 64'(s_tready_o), 64'd1);
      check("t6_abort_once", 64'(abort_o), 64'd0);
      @(negedge clk_i);
    end
    s_tvalid_i[0] = 1'b0; s_tlast_i[0] = 1'b0;
    #1;
    check("t6_idle_grant", 64'(grant_o), 64'd0);
    @(negedge clk_i);
    #1;
    check("t6_req1_grant", 64'(grant_o), 64'd2);
    check("t6_req1_data",  m_tdata_o, 64'h1111_2222_3333_4444);
    check("t6_req1_last",  64'({m_tvalid_o, m_tlast_o}), 64'd3);
    @(negedge clk_i);
    s_tvalid_i = '0;
    #1;
    check("t6_done_busy", 64'(busy_o), 64'd0);
    @(negedge clk_i);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
